// File: rtl/cbu_period_ctrl.sv
// Sequencing controller for a cascaded CAI/CAO counter chain: turns PERIOD into a
// load value, runs the chain in one-shot or auto-reload mode and reports ticks.
module cbu_period_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic             START,
   input  logic             STOP,
   input  logic             HOLD,
   input  logic             MODE,
   input  logic [WIDTH-1:0] PERIOD,
   input  logic             CNT_CAO,
   output logic [WIDTH-1:0] CNT_D,
   output logic             CNT_LD,
   output logic             CNT_CS,
   output logic             CNT_PS,
   output logic             CNT_EN,
   output logic             CNT_CAI,
   output logic             BUSY,
   output logic             TICK,
   output logic             DONE,
   output logic             ERR,
   output logic [7:0]       TCNT
);

   localparam int unsigned TCNT_W = 8;

   typedef enum logic [1:0] {
      S_CLR  = 2'd0,
      S_IDLE = 2'd1,
      S_LOAD = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    per_q, per_d;
   logic                mode_q, mode_d;
   logic                tick_q, tick_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

   logic                cs_c, ld_c, en_c, busy_c;

   // State and latched-parameter registers
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= S_CLR;
         per_q   <= '0;
         mode_q  <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         mode_q  <= mode_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
         err_q   <= err_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Next state; STOP outranks terminal count in RUN
   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      mode_d  = mode_q;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      tcnt_d  = tcnt_q;
      case (state_q)
         S_CLR: state_d = S_IDLE;
         S_IDLE: begin
            if (START) begin
               if (PERIOD != '0) begin
                  per_d   = PERIOD;
                  mode_d  = MODE;
                  tcnt_d  = '0;
                  state_d = S_LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD: state_d = STOP ? S_IDLE : S_RUN;
         S_RUN: begin
            if (STOP) begin
               state_d = S_IDLE;
            end else if (CNT_CAO) begin
               tick_d = 1'b1;
               if (tcnt_q != '1) tcnt_d = tcnt_q + TCNT_W'(1);
               if (!mode_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_CLR;
      endcase
   end

   // Chain controls; clear always wins over load
   always_comb begin
      cs_c   = 1'b0;
      ld_c   = 1'b0;
      en_c   = 1'b0;
      busy_c = 1'b0;
      case (state_q)
         S_CLR: cs_c = 1'b1;
         S_LOAD: begin
            busy_c = 1'b1;
            if (STOP) cs_c = 1'b1;
            else      ld_c = 1'b1;
         end
         S_RUN: begin
            busy_c = 1'b1;
            en_c   = !HOLD;
            if (STOP) begin
               cs_c = 1'b1;
            end else if (CNT_CAO) begin
               if (mode_q) ld_c = 1'b1;
               else        cs_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Load value makes the chain hit all-ones after PERIOD-1 increments
   assign CNT_D   = WIDTH'((~per_q) + WIDTH'(1));
   assign CNT_LD  = ld_c;
   assign CNT_CS  = cs_c;
   assign CNT_PS  = 1'b0;
   assign CNT_EN  = en_c;
   assign CNT_CAI = en_c;
   assign BUSY    = busy_c;
   assign TICK    = tick_q;
   assign DONE    = done_q;
   assign ERR     = err_q;
   assign TCNT    = tcnt_q;

endmodule

// File: tb/tb_cbu_period_ctrl.sv
// Directed bench for cbu_period_ctrl with a behavioural 8-bit counter chain.
module tb_cbu_period_ctrl;

   localparam int unsigned W = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0, hold = 1'b0, mode = 1'b0;
   logic [W-1:0]  period = '0;
   logic          cnt_cao;
   logic [W-1:0]  cnt_d;
   logic          cnt_ld, cnt_cs, cnt_ps, cnt_en, cnt_cai;
   logic          busy, tick, done, err;
   logic [7:0]    tcnt;
   logic [W-1:0]  chain_q = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cbu_period_ctrl #(.WIDTH(W)) dut (
      .CLK(clk), .RSTN(rst_n), .START(start), .STOP(stop), .HOLD(hold),
      .MODE(mode), .PERIOD(period), .CNT_CAO(cnt_cao), .CNT_D(cnt_d),
      .CNT_LD(cnt_ld), .CNT_CS(cnt_cs), .CNT_PS(cnt_ps), .CNT_EN(cnt_en),
      .CNT_CAI(cnt_cai), .BUSY(busy), .TICK(tick), .DONE(done), .ERR(err),
      .TCNT(tcnt)
   );

   // Counter chain: clear > load > count, carry-out of the top slice
   always_ff @(posedge clk) begin
      if (cnt_cs)                 chain_q <= '0;
      else if (cnt_ld)            chain_q <= cnt_d;
      else if (cnt_en && cnt_cai) chain_q <= chain_q + W'(1);
   end
   assign cnt_cao = cnt_cai && (chain_q == '1);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if ({tick, done, err} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {tick, done, err}); end
      checks++; if (tcnt !== 8'h00) begin errors++; $display("FAIL rst_tcnt got %h exp 00", tcnt); end
      checks++; if (cnt_ps !== 1'b0) begin errors++; $display("FAIL rst_ps got %b exp 0", cnt_ps); end
      checks++; if (cnt_cs !== 1'b1) begin errors++; $display("FAIL rst_cs got %b exp 1", cnt_cs); end
      rst_n = 1'b1;
      #1;
      checks++; if (cnt_cs !== 1'b1) begin errors++; $display("FAIL clr_cycle_cs got %b exp 1", cnt_cs); end
      step();
      checks++; if ({cnt_cs, cnt_ld, cnt_en, busy} !== 4'b0000) begin errors++; $display("FAIL idle_ctrl got %b exp 0000", {cnt_cs, cnt_ld, cnt_en, busy}); end
      checks++; if (chain_q !== 8'h00) begin errors++; $display("FAIL idle_chain got %h exp 00", chain_q); end
   endtask

   task automatic test_oneshot();
      start = 1'b1; mode = 1'b0; period = 8'd5;
      step();
      start = 1'b0; period = 8'd9;
      #1;
      checks++; if ({cnt_ld, cnt_cs, busy, cnt_cai} !== 4'b1010) begin errors++; $display("FAIL os_load_ctrl got %b exp 1010", {cnt_ld, cnt_cs, busy, cnt_cai}); end
      checks++; if (cnt_d !== 8'hFB) begin errors++; $display("FAIL os_cnt_d got %h exp fb", cnt_d); end
      for (int c = 2; c <= 6; c++) begin
         step();
         checks++; if (cnt_cao !== (c == 6)) begin errors++; $display("FAIL os_cao c%0d got %b exp %b", c, cnt_cao, c == 6); end
         checks++; if ({cnt_en, busy} !== 2'b11) begin errors++; $display("FAIL os_run c%0d got %b exp 11", c, {cnt_en, busy}); end
      end
      checks++; if ({cnt_cs, cnt_ld} !== 2'b10) begin errors++; $display("FAIL os_tc_ctrl got %b exp 10", {cnt_cs, cnt_ld}); end
      step();
      checks++; if ({tick, done} !== 2'b11) begin errors++; $display("FAIL os_done got %b exp 11", {tick, done}); end
      checks++; if (tcnt !== 8'd1) begin errors++; $display("FAIL os_tcnt got %0d exp 1", tcnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL os_busy got %b exp 0", busy); end
      checks++; if (chain_q !== 8'h00) begin errors++; $display("FAIL os_chain got %h exp 00", chain_q); end
      step();
      checks++; if ({tick, done} !== 2'b00) begin errors++; $display("FAIL os_pulse_end got %b exp 00", {tick, done}); end
   endtask

   task automatic test_autoreload();
      logic [W-1:0] exp_chain;
      start = 1'b1; mode = 1'b1; period = 8'd3;
      step();
      start = 1'b0; mode = 1'b0;
      step();
      for (int k = 0; k <= 30; k++) begin
         start  = (k == 10);
         period = (k >= 10) ? 8'd7 : 8'd3;
         #1;
         exp_chain = 8'hFD + W'(k % 3);
         checks++; if (chain_q !== exp_chain) begin errors++; $display("FAIL ar_chain k%0d got %h exp %h", k, chain_q, exp_chain); end
         checks++; if (tick !== (k >= 3 && k % 3 == 0)) begin errors++; $display("FAIL ar_tick k%0d got %b exp %b", k, tick, k >= 3 && k % 3 == 0); end
         checks++; if ({err, done} !== 2'b00) begin errors++; $display("FAIL ar_err_done k%0d got %b exp 00", k, {err, done}); end
         if (k < 30) step();
      end
      start = 1'b0;
      checks++; if (tcnt !== 8'd10) begin errors++; $display("FAIL ar_tcnt10 got %0d exp 10", tcnt); end
      for (int i = 0; i < 900; i++) step();
      checks++; if (tcnt !== 8'd255) begin errors++; $display("FAIL ar_tcnt_sat got %0d exp 255", tcnt); end
      stop = 1'b1;
      #1;
      checks++; if (cnt_cs !== 1'b1) begin errors++; $display("FAIL ar_stop_cs got %b exp 1", cnt_cs); end
      step();
      stop = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_stop_busy got %b exp 0", busy); end
      checks++; if (chain_q !== 8'h00) begin errors++; $display("FAIL ar_stop_chain got %h exp 00", chain_q); end
   endtask

   task automatic test_hold();
      start = 1'b1; mode = 1'b1; period = 8'd4;
      step();
      start = 1'b0;
      for (int c = 2; c <= 16; c++) begin
         step();
         hold = (c == 7 || c == 8);
         #1;
         checks++; if (tick !== (c == 6 || c == 12 || c == 16)) begin errors++; $display("FAIL hold_tick c%0d got %b exp %b", c, tick, c == 6 || c == 12 || c == 16); end
         checks++; if (cnt_en !== !hold) begin errors++; $display("FAIL hold_en c%0d got %b exp %b", c, cnt_en, !hold); end
      end
      hold = 1'b0;
      stop = 1'b1;
      step();
      stop = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_stop_busy got %b exp 0", busy); end
   endtask

   task automatic test_stop_at_cao();
      start = 1'b1; mode = 1'b1; period = 8'd3;
      step();
      start = 1'b0;
      step();
      step();
      step();
      stop = 1'b1;
      #1;
      checks++; if (cnt_cao !== 1'b1) begin errors++; $display("FAIL sc_cao got %b exp 1", cnt_cao); end
      checks++; if ({cnt_cs, cnt_ld} !== 2'b10) begin errors++; $display("FAIL sc_ctrl got %b exp 10", {cnt_cs, cnt_ld}); end
      step();
      stop = 1'b0;
      #1;
      checks++; if ({tick, done, busy} !== 3'b000) begin errors++; $display("FAIL sc_after got %b exp 000", {tick, done, busy}); end
      checks++; if (tcnt !== 8'd0) begin errors++; $display("FAIL sc_tcnt got %0d exp 0", tcnt); end
      checks++; if (chain_q !== 8'h00) begin errors++; $display("FAIL sc_chain got %h exp 00", chain_q); end
   endtask

   task automatic test_err();
      start = 1'b1; period = 8'd0;
      step();
      start = 1'b0;
      #1;
      checks++; if ({err, busy} !== 2'b10) begin errors++; $display("FAIL err_pulse got %b exp 10", {err, busy}); end
      step();
      checks++; if ({err, busy} !== 2'b00) begin errors++; $display("FAIL err_end got %b exp 00", {err, busy}); end
   endtask

   task automatic test_reset_midrun();
      start = 1'b1; mode = 1'b1; period = 8'd2;
      step();
      start = 1'b0;
      for (int c = 2; c <= 6; c++) step();
      #1;
      checks++; if ({tick, tcnt} !== {1'b1, 8'd2}) begin errors++; $display("FAIL mr_pre got %b/%0d exp 1/2", tick, tcnt); end
      rst_n = 1'b0;
      #1;
      checks++; if ({tick, done, err, busy, cnt_en, cnt_cai, cnt_ld} !== 7'b0) begin errors++; $display("FAIL mr_async got %b exp 0000000", {tick, done, err, busy, cnt_en, cnt_cai, cnt_ld}); end
      checks++; if (tcnt !== 8'd0) begin errors++; $display("FAIL mr_tcnt got %0d exp 0", tcnt); end
      checks++; if (cnt_cs !== 1'b1) begin errors++; $display("FAIL mr_cs got %b exp 1", cnt_cs); end
      step();
      rst_n = 1'b1;
      #1;
      checks++; if ({cnt_cs, busy} !== 2'b10) begin errors++; $display("FAIL mr_clr got %b exp 10", {cnt_cs, busy}); end
      step();
      checks++; if (chain_q !== 8'h00) begin errors++; $display("FAIL mr_chain got %h exp 00", chain_q); end
      checks++; if (cnt_cs !== 1'b0) begin errors++; $display("FAIL mr_idle_cs got %b exp 0", cnt_cs); end
      start = 1'b1; mode = 1'b0; period = 8'd2;
      step();
      start = 1'b0;
      #1;
      checks++; if ({cnt_ld, busy, cnt_d} !== {2'b11, 8'hFE}) begin errors++; $display("FAIL mr_restart got %b%b/%h exp 11/fe", cnt_ld, busy, cnt_d); end
      for (int i = 0; i < 4; i++) step();
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_hold();
      test_stop_at_cao();
      test_err();
      test_reset_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
